// File: rtl/vector_acc_sched_pkg.sv
// vacc_pkg: shared FSM state type and default widths for the vector accumulator sequencer.
//   State: IDLE (waiting for a job), STREAM (issuing feature vector reads).
package vacc_pkg;
   typedef enum logic {IDLE, STREAM} state_t;
   localparam int DATA_W      = 32;
   localparam int PVADD       = 128;
   localparam int ADDR_W      = 16;
   localparam int CNT_W       = 10;
   localparam int DST_DEPTH_D = 4;
endpackage

// File: rtl/vector_acc_sched_if.sv
// vector_acc_sched_if: job, feature-read, accumulator and result-write signals of the sequencer.
//   master: job source / feature buffer / accumulator / result buffer side.
//   slave:  the sequencer (vector_acc_sched).
interface vector_acc_sched_if
   import vacc_pkg::*;
#(
   parameter int dataWidth = DATA_W,
   parameter int pvadd     = PVADD,
   parameter int addrWidth = ADDR_W,
   parameter int cntWidth  = CNT_W
);
   logic                         job_valid;
   logic                         job_ready;
   logic [addrWidth-1:0]         job_base;
   logic [cntWidth-1:0]          job_len;
   logic [addrWidth-1:0]         job_dst;
   logic                         rd_en;
   logic [addrWidth-1:0]         rd_addr;
   logic [dataWidth*pvadd-1:0]   rd_data;
   logic [dataWidth*pvadd-1:0]   acc_in;
   logic                         acc_lastin;
   logic [dataWidth*pvadd-1:0]   acc_out;
   logic                         acc_valid;
   logic                         acc_lastout;
   logic                         wr_en;
   logic [addrWidth-1:0]         wr_addr;
   logic [dataWidth*pvadd-1:0]   wr_data;
   modport master (
      output job_valid, job_base, job_len, job_dst, rd_data, acc_out, acc_valid, acc_lastout,
      input  job_ready, rd_en, rd_addr, acc_in, acc_lastin, wr_en, wr_addr, wr_data
   );
   modport slave (
      input  job_valid, job_base, job_len, job_dst, rd_data, acc_out, acc_valid, acc_lastout,
      output job_ready, rd_en, rd_addr, acc_in, acc_lastin, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/vector_acc_sched_dst_fifo.sv
// dst_fifo: destination-address FIFO for in-flight segments, fall-through read.
//   clk, rst (async active-low); push/din, pop/dout; full, empty, count.
//   Push and pop in the same cycle are both performed.
module dst_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp, rp;
   logic             do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + PW'(1);
         if (do_pop) rp <= rp + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/vector_acc_sched.sv
// vector_acc_sched: streams segment jobs into the vectorAdd accumulator and retires sums in job order.
//   clk, rst (async active-low); bus (slave): job handshake, feature read port,
//   accumulator drive/return, result write port; busy; err_orphan (sticky).
module vector_acc_sched
   import vacc_pkg::*;
#(
   parameter int dataWidth = DATA_W,
   parameter int pvadd     = PVADD,
   parameter int addrWidth = ADDR_W,
   parameter int cntWidth  = CNT_W,
   parameter int DST_DEPTH = DST_DEPTH_D
) (
   input  logic                clk,
   input  logic                rst,
   vector_acc_sched_if.slave   bus,
   output logic                busy,
   output logic                err_orphan
);
   localparam int VW = dataWidth * pvadd;
   state_t                   state, state_nx;
   logic [addrWidth-1:0]     addr, dst_head, wr_addr_q;
   logic [cntWidth-1:0]      rem;
   logic                     zero_job, vld_d1, last_d1, zero_d1;
   logic                     ready, rd_en, push, pop, lastbeat, full, empty, wr_en_q;
   logic [VW-1:0]            wr_data_q;
   logic [$clog2(DST_DEPTH):0] count;
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      rd_en    = 1'b0;
      if (state == IDLE) begin
         ready = !full;
         if (bus.job_valid && !full) state_nx = STREAM;
      end else begin
         rd_en = !zero_job;
         if (rem == cntWidth'(1)) state_nx = IDLE;
      end
   end
   assign push     = bus.job_valid && ready;
   assign lastbeat = bus.acc_valid && bus.acc_lastout;
   assign pop      = lastbeat && !empty;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr     <= '0;
         rem      <= '0;
         zero_job <= 1'b0;
         vld_d1   <= 1'b0;
         last_d1  <= 1'b0;
         zero_d1  <= 1'b0;
      end else begin
         state   <= state_nx;
         vld_d1  <= state == STREAM;
         last_d1 <= state == STREAM && rem == cntWidth'(1);
         zero_d1 <= zero_job;
         if (push) begin
            // A zero-length job still runs one beat so it emits a +0.0 sum with lastin
            addr     <= bus.job_base;
            rem      <= bus.job_len == '0 ? cntWidth'(1) : bus.job_len;
            zero_job <= bus.job_len == '0;
         end else if (state == STREAM) begin
            addr <= addr + addrWidth'(1);
            rem  <= rem - cntWidth'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         err_orphan <= 1'b0;
      end else begin
         wr_en_q <= pop;
         if (pop) begin
            wr_addr_q <= dst_head;
            wr_data_q <= bus.acc_out;
         end
         if (lastbeat && empty) err_orphan <= 1'b1;
      end
   end
   dst_fifo #(.WIDTH(addrWidth), .DEPTH(DST_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (bus.job_dst),
      .pop   (pop),
      .dout  (dst_head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign bus.job_ready  = ready;
   assign bus.rd_en      = rd_en;
   assign bus.rd_addr    = addr;
   // The accumulator adds every cycle, so anything that is not a live read must be zero
   assign bus.acc_in     = vld_d1 && !zero_d1 ? bus.rd_data : '0;
   assign bus.acc_lastin = last_d1;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign busy           = state != IDLE || count != '0;
endmodule

// File: tb/tb_vector_acc_sched.sv
// tb_vector_acc_sched: scoreboard bench for vector_acc_sched with a feature buffer and a latency-12 accumulator model.
module tb_vector_acc_sched;
   import vacc_pkg::*;
   localparam int DW = 32, PV = 128, AW = 16, CW = 10, DEPTH = 4, LAT = 12, VW = DW * PV;
   typedef struct {
      logic [AW-1:0] dst;
      logic [VW-1:0] data;
   } exp_t;
   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   busy, err_orphan;
   logic   inj = 1'b0;
   exp_t   sb[$];
   int     n_cmp = 0, n_err = 0, n_wr = 0;
   logic [31:0] last_lane0 = '0;
   always #5 clk = ~clk;
   vector_acc_sched_if #(.dataWidth(DW), .pvadd(PV), .addrWidth(AW), .cntWidth(CW)) bus ();
   vector_acc_sched #(.dataWidth(DW), .pvadd(PV), .addrWidth(AW), .cntWidth(CW), .DST_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .busy       (busy),
      .err_orphan (err_orphan)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] i2f(input int n);
      logic [23:0] v, m;
      int e;
      if (n == 0) return 32'h0;
      v = n[23:0];
      e = 0;
      for (int i = 0; i < 24; i++) if (v[i]) e = i;
      m = v << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction
   function automatic int f2i(input logic [31:0] b);
      logic [23:0] m;
      int e;
      if (b[30:0] == 31'h0) return 0;
      e = int'(b[30:23]) - 127;
      m = {1'b1, b[22:0]};
      return int'(m >> (23 - e));
   endfunction
   function automatic int bufval(input logic [AW-1:0] a, input int l);
      logic [AW-1:0] t;
      t = (a + AW'(1)) & AW'(15);
      return int'(t) + (a[8] ? l % 5 : 0);
   endfunction
   function automatic logic [VW-1:0] exp_vec(input logic [AW-1:0] base, input int len);
      logic [VW-1:0] v;
      logic [AW-1:0] a;
      int s;
      for (int l = 0; l < PV; l++) begin
         s = 0;
         for (int k = 0; k < len; k++) begin
            a = base + AW'(k);
            s += bufval(a, l);
         end
         v[l*DW +: DW] = i2f(s);
      end
      return v;
   endfunction
   function automatic int lane_sum(input int prev, input logic [31:0] x);
      return prev + f2i(x);
   endfunction
   // Feature buffer: one-cycle read latency, junk when not reading
   always @(posedge clk) begin
      for (int l = 0; l < PV; l++)
         bus.rd_data[l*DW +: DW] <= bus.rd_en ? i2f(bufval(bus.rd_addr, l)) : 32'h47000000;
   end
   // Accumulator model: adds every cycle, emits sum LAT cycles after lastin
   int            sum [PV];
   logic [VW-1:0] pd [LAT];
   logic          pl [LAT];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) begin
            pd[i] <= '0;
            pl[i] <= 1'b0;
         end
         for (int l = 0; l < PV; l++) sum[l] <= 0;
      end else begin
         for (int l = 0; l < PV; l++) begin
            sum[l] <= bus.acc_lastin ? 0 : lane_sum(sum[l], bus.acc_in[l*DW +: DW]);
            pd[0][l*DW +: DW] <= i2f(lane_sum(sum[l], bus.acc_in[l*DW +: DW]));
         end
         pl[0] <= bus.acc_lastin;
         for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            pl[i] <= pl[i-1];
         end
      end
   end
   assign bus.acc_out     = pd[LAT-1];
   assign bus.acc_lastout = pl[LAT-1] | inj;
   assign bus.acc_valid   = 1'b1;
   // Result monitor: every write must match the oldest outstanding job
   always @(negedge clk) begin
      exp_t e;
      int   idx;
      if (rst && bus.wr_en) begin
         n_wr++;
         last_lane0 = bus.wr_data[31:0];
         if (sb.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(e.dst));
            idx = 0;
            for (int l = PV - 1; l >= 0; l--)
               if (bus.wr_data[l*DW +: DW] !== e.data[l*DW +: DW]) idx = l;
            check("wr_data", {32'(idx), bus.wr_data[idx*DW +: DW]}, {32'(idx), e.data[idx*DW +: DW]});
         end
      end
   end
   task automatic send(input logic [AW-1:0] base, input int len, input logic [AW-1:0] dst);
      int n = 0;
      bus.job_base  = base;
      bus.job_len   = CW'(len);
      bus.job_dst   = dst;
      bus.job_valid = 1'b1;
      while (!bus.job_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.job_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         bus.job_valid = 1'b0;
      end else begin
         sb.push_back('{dst, exp_vec(base, len)});
         @(negedge clk);
         bus.job_valid = 1'b0;
      end
   endtask
   task automatic drain();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(n < 500), 64'd1);
      repeat (2) @(negedge clk);
   endtask
   task automatic reset_checks(input string tag);
      check({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
      check({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
      check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
      check({tag, "_acc_in_zero"}, 64'(bus.acc_in == '0), 64'd1);
      check({tag, "_acc_lastin"}, 64'(bus.acc_lastin), 64'd0);
      check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
      check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
      check({tag, "_wr_data_zero"}, 64'(bus.wr_data == '0), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_err_orphan"}, 64'(err_orphan), 64'd0);
   endtask
   initial begin
      int n;
      bus.job_valid = 1'b0;
      bus.job_base  = '0;
      bus.job_len   = '0;
      bus.job_dst   = '0;
      repeat (3) @(negedge clk);
      reset_checks("rst");
      rst = 1'b1;
      @(negedge clk);
      // Basic 3-vector job
      send(16'h10, 3, 16'h80);
      check("t1_rd_en", 64'(bus.rd_en), 64'd1);
      check("t1_rd_addr0", 64'(bus.rd_addr), 64'h10);
      check("t1_lastin0", 64'(bus.acc_lastin), 64'd0);
      @(negedge clk);
      check("t1_rd_addr1", 64'(bus.rd_addr), 64'h11);
      check("t1_acc_in_l0", 64'(bus.acc_in[31:0]), 64'h3F800000);
      check("t1_acc_in_l127", 64'(bus.acc_in[VW-1 -: 32]), 64'h3F800000);
      check("t1_lastin1", 64'(bus.acc_lastin), 64'd0);
      @(negedge clk);
      check("t1_rd_addr2", 64'(bus.rd_addr), 64'h12);
      check("t1_lastin2", 64'(bus.acc_lastin), 64'd0);
      @(negedge clk);
      check("t1_rd_en_off", 64'(bus.rd_en), 64'd0);
      check("t1_lastin3", 64'(bus.acc_lastin), 64'd1);
      drain();
      check("t1_sum6", 64'(last_lane0), 64'h40C00000);
      // Zero-length job then a 2-vector job
      send(16'h20, 0, 16'h5);
      check("t2_zero_rd_en", 64'(bus.rd_en), 64'd0);
      @(negedge clk);
      check("t2_zero_lastin", 64'(bus.acc_lastin), 64'd1);
      check("t2_zero_acc_in", 64'(bus.acc_in == '0), 64'd1);
      send(16'h120, 2, 16'h6);
      drain();
      // Five back-to-back jobs: FIFO fills, fifth waits; last one wraps the address space
      for (int i = 0; i < 4; i++) send(16'h100 + AW'(16 * i), 2, 16'h80 + AW'(i));
      repeat (2) @(negedge clk);
      check("t3_ready_full", 64'(bus.job_ready), 64'd0);
      check("t3_count_full", 64'(dut.u_fifo.count), 64'd4);
      check("t3_busy", 64'(busy), 64'd1);
      send(16'hFFFF, 3, 16'h84);
      drain();
      // Push coinciding with pop
      send(16'h300, 1, 16'h31);
      n = 0;
      while (!bus.acc_lastout && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_lastout_seen", 64'(bus.acc_lastout), 64'd1);
      check("t4_ready", 64'(bus.job_ready), 64'd1);
      check("t4_count_pre", 64'(dut.u_fifo.count), 64'd1);
      bus.job_base  = 16'h310;
      bus.job_len   = CW'(2);
      bus.job_dst   = 16'h32;
      bus.job_valid = 1'b1;
      sb.push_back('{16'h32, exp_vec(16'h310, 2)});
      @(negedge clk);
      bus.job_valid = 1'b0;
      check("t4_count_post", 64'(dut.u_fifo.count), 64'd1);
      drain();
      // Orphan lastout
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      check("t5_orphan_set", 64'(err_orphan), 64'd1);
      check("t5_no_wr0", 64'(bus.wr_en), 64'd0);
      @(negedge clk);
      check("t5_no_wr1", 64'(bus.wr_en), 64'd0);
      check("t5_orphan_sticky", 64'(err_orphan), 64'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_orphan_clr", 64'(err_orphan), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      // Reset in the middle of an 8-vector stream
      send(16'h200, 8, 16'h40);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      reset_checks("t6");
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(16'h210, 2, 16'h41);
      drain();
      check("total_writes", 64'(n_wr), 64'd11);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
